vram_port: RTL and testbench

- CPU-side writer and reader for the character and colour RAMs. It is the other end of the video fetch interface.
- Owns two 1024x8 single-access arrays:
  - char RAM, CPU window 0x3000-0x33FF
  - colour RAM, CPU window 0x3400-0x37FF
- Arbitrates one access slot per clock between the video fetcher (highest priority), CPU reads and buffered CPU writes.
- Sits between the Z80 bus decode and the video timing block.

---
 rtl/vram_port.sv | 154 +++++++++++++++
 tb/tb_vram_port.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port.sv
// CPU-side port for the 1024x8 character and colour RAMs: buffers CPU writes,
// forwards reads from the write buffer, and shares one slot per clock with the video fetcher.
module vram_port #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [4:0]  BASE       = 5'b00110
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    output logic        cpu_rd_valid,
    output logic        cpu_wait,
    output logic        vram_sel,
    input  logic [9:0]  video_addr,
    input  logic        video_rd,
    output logic [7:0]  video_data,
    output logic [7:0]  video_color
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [7:0] char_mem [1024];
    logic [7:0] col_mem  [1024];

    logic       fifo_arr_q [FIFO_DEPTH];
    logic [9:0] fifo_idx_q [FIFO_DEPTH];
    logic [7:0] fifo_dat_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_arr_q;
    logic [9:0]    rd_idx_q;
    logic          cpu_wait_q, cpu_wait_d;
    logic          cpu_rd_valid_q;
    logic [7:0]    cpu_dout_q;
    logic [7:0]    video_data_q, video_color_q;

    logic          wr_acc, rd_acc, rd_hit, rd_miss;
    logic          slot_video, slot_cpu, slot_commit;
    logic          fwd_hit;
    logic [7:0]    fwd_dat;
    logic [PW-1:0] pos;

    always_comb begin
        vram_sel = (cpu_addr[15:11] == BASE);
        wr_acc   = cpu_wr && vram_sel && !cpu_wait_q;
        rd_acc   = cpu_rd && !cpu_wr && vram_sel && !cpu_wait_q;

        slot_video  = video_rd;
        slot_cpu    = !video_rd && rd_pend_q;
        slot_commit = !video_rd && !rd_pend_q && (cnt_q != '0);

        // Walk oldest to youngest so the last match left standing is the youngest entry.
        fwd_hit = 1'b0;
        fwd_dat = '0;
        pos     = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            pos = rd_ptr_q + PW'(i);
            if ((CW'(i) < cnt_q) && (fifo_arr_q[pos] == cpu_addr[10]) &&
                (fifo_idx_q[pos] == cpu_addr[9:0])) begin
                fwd_hit = 1'b1;
                fwd_dat = fifo_dat_q[pos];
            end
        end
        rd_hit  = rd_acc && fwd_hit;
        rd_miss = rd_acc && !fwd_hit;

        cnt_d = cnt_q;
        if (wr_acc && !slot_commit) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_acc && slot_commit) begin
            cnt_d = cnt_q - CW'(1);
        end

        rd_pend_d = rd_pend_q;
        if (slot_cpu) begin
            rd_pend_d = 1'b0;
        end
        if (rd_miss) begin
            rd_pend_d = 1'b1;
        end

        // Wait stays up through the read-data cycle and drops the cycle after.
        cpu_wait_d = (cnt_d == FULL) || rd_pend_d || slot_cpu;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            rd_pend_q      <= 1'b0;
            rd_arr_q       <= 1'b0;
            rd_idx_q       <= '0;
            cpu_wait_q     <= 1'b0;
            cpu_rd_valid_q <= 1'b0;
            cpu_dout_q     <= '0;
            video_data_q   <= '0;
            video_color_q  <= '0;
        end else begin
            cnt_q          <= cnt_d;
            rd_pend_q      <= rd_pend_d;
            cpu_wait_q     <= cpu_wait_d;
            cpu_rd_valid_q <= rd_hit || slot_cpu;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (slot_commit) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (rd_miss) begin
                rd_arr_q <= cpu_addr[10];
                rd_idx_q <= cpu_addr[9:0];
            end
            if (rd_hit) begin
                cpu_dout_q <= fwd_dat;
            end else if (slot_cpu) begin
                cpu_dout_q <= rd_arr_q ? col_mem[rd_idx_q] : char_mem[rd_idx_q];
            end
            if (slot_video) begin
                video_data_q  <= char_mem[video_addr];
                video_color_q <= col_mem[video_addr];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_acc) begin
            fifo_arr_q[wr_ptr_q] <= cpu_addr[10];
            fifo_idx_q[wr_ptr_q] <= cpu_addr[9:0];
            fifo_dat_q[wr_ptr_q] <= cpu_din;
        end
        if (slot_commit) begin
            if (fifo_arr_q[rd_ptr_q]) begin
                col_mem[fifo_idx_q[rd_ptr_q]] <= fifo_dat_q[rd_ptr_q];
            end else begin
                char_mem[fifo_idx_q[rd_ptr_q]] <= fifo_dat_q[rd_ptr_q];
            end
        end
    end

    assign cpu_dout     = cpu_dout_q;
    assign cpu_rd_valid = cpu_rd_valid_q;
    assign cpu_wait     = cpu_wait_q;
    assign video_data   = video_data_q;
    assign video_color  = video_color_q;

endmodule

// File: tb/tb_vram_port.sv
// Scoreboard bench for vram_port: a transaction-level model of the write queue, pending
// read and RAM contents predicts every response; a separate monitor compares each cycle.
module tb_vram_port;

    localparam int unsigned DEPTH  = 4;
    localparam logic [4:0]  BASE_C = 5'b00110;

    logic        clk_sys;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_wr, cpu_rd;
    logic [7:0]  cpu_dout;
    logic        cpu_rd_valid, cpu_wait, vram_sel;
    logic [9:0]  video_addr;
    logic        video_rd;
    logic [7:0]  video_data, video_color;

    vram_port #(.FIFO_DEPTH(DEPTH), .BASE(BASE_C)) dut (
        .clk_sys(clk_sys), .reset(reset), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .cpu_rd_valid(cpu_rd_valid),
        .cpu_wait(cpu_wait), .vram_sel(vram_sel), .video_addr(video_addr),
        .video_rd(video_rd), .video_data(video_data), .video_color(video_color)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       arr;
        logic [9:0] idx;
        logic [7:0] dat;
    } wr_t;

    // reference model state
    wr_t        wq[$];
    logic [7:0] rq[$];
    logic [15:0] vq[$];
    logic [7:0] m_char [1024];
    logic [7:0] m_col  [1024];
    logic       m_pend, m_parr, m_wait, m_valid_exp;
    logic [9:0] m_pidx;
    logic [7:0] m_vd, m_vc, m_dout;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete(); rq.delete(); vq.delete();
        m_pend = 0; m_parr = 0; m_pidx = '0; m_wait = 0; m_valid_exp = 0;
        m_vd = '0; m_vc = '0; m_dout = '0;
    endtask

    task automatic model_step();
        logic sel, had_head, pend_old, fire, hit;
        wr_t  e;
        sel      = (cpu_addr[15:11] == BASE_C);
        had_head = (wq.size() != 0);
        pend_old = m_pend;
        fire = 0; hit = 0; m_valid_exp = 0;
        if (!m_wait && sel && cpu_wr) begin
            e.arr = cpu_addr[10]; e.idx = cpu_addr[9:0]; e.dat = cpu_din;
            wq.push_back(e);
        end else if (!m_wait && sel && cpu_rd) begin
            for (int k = int'(wq.size()) - 1; k >= 0; k--) begin
                if (!hit && wq[k].arr == cpu_addr[10] && wq[k].idx == cpu_addr[9:0]) begin
                    hit = 1;
                    rq.push_back(wq[k].dat);
                end
            end
            if (hit) m_valid_exp = 1;
            else begin
                m_pend = 1; m_parr = cpu_addr[10]; m_pidx = cpu_addr[9:0];
            end
        end
        if (video_rd) begin
            vq.push_back({m_char[video_addr], m_col[video_addr]});
        end else if (pend_old) begin
            rq.push_back(m_parr ? m_col[m_pidx] : m_char[m_pidx]);
            m_pend = 0; fire = 1; m_valid_exp = 1;
        end else if (had_head) begin
            e = wq.pop_front();
            if (e.arr) m_col[e.idx] = e.dat;
            else       m_char[e.idx] = e.dat;
        end
        m_wait = (wq.size() == DEPTH) || m_pend || fire;
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic [15:0] a,
                       input logic [7:0] d, input logic vr, input logic [9:0] va);
        @(negedge clk_sys);
        cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_din = d;
        video_rd = vr; video_addr = va;
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 16'h0000, 8'h00, 0, 10'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1;
        cpu_wr = 0; cpu_rd = 0; cpu_addr = '0; cpu_din = '0; video_rd = 0; video_addr = '0;
        model_reset();
        #1;
        chk("rst_video_data", {8'h0, video_data}, 16'h0);
        chk("rst_video_color", {8'h0, video_color}, 16'h0);
        chk("rst_cpu_dout", {8'h0, cpu_dout}, 16'h0);
        chk("rst_rd_valid", {15'h0, cpu_rd_valid}, 16'h0);
        chk("rst_wait", {15'h0, cpu_wait}, 16'h0);
        @(negedge clk_sys);
        reset = 0;
        model_step();
    endtask

    task automatic after_edge();
        @(posedge clk_sys);
        #3;
    endtask

    // monitor: compares DUT outputs against the model every cycle
    initial begin
        logic vr_s;
        forever begin
            @(posedge clk_sys);
            vr_s = video_rd && !reset;
            #2;
            if (vr_s) begin
                if (vq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL video_queue: got fetch expected none (t=%0t)", $time);
                end else begin
                    {m_vd, m_vc} = vq.pop_front();
                end
            end
            chk("video_data", {8'h0, video_data}, {8'h0, m_vd});
            chk("video_color", {8'h0, video_color}, {8'h0, m_vc});
            chk("cpu_wait", {15'h0, cpu_wait}, {15'h0, m_wait});
            chk("cpu_rd_valid", {15'h0, cpu_rd_valid}, {15'h0, m_valid_exp});
            if (cpu_rd_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL read_queue: got valid expected none (t=%0t)", $time);
                end else begin
                    m_dout = rq.pop_front();
                end
            end
            chk("cpu_dout", {8'h0, cpu_dout}, {8'h0, m_dout});
        end
    end

    initial begin
        logic [7:0]  old4, old101;
        logic [15:0] a;
        logic [9:0]  idx;
        int unsigned vcnt, r;
        reset = 0; cpu_wr = 0; cpu_rd = 0; cpu_addr = '0; cpu_din = '0;
        video_rd = 0; video_addr = '0;
        model_reset();
        #1 reset = 1;
        @(negedge clk_sys);
        reset = 0;
        model_step();

        // give every RAM location a known value
        for (int i = 0; i < 1024; i++) begin
            cyc(1, 0, 16'h3000 | 16'(i), 8'($urandom), 0, 10'd0);
            cyc(1, 0, 16'h3400 | 16'(i), 8'($urandom), 0, 10'd0);
        end
        idle(4);

        // char round trip
        cyc(1, 0, 16'h3005, 8'h41, 0, 10'd0);
        idle(2);
        cyc(0, 0, 16'h0000, 8'h00, 1, 10'd5);
        after_edge();
        chk("char_rt_data", {8'h0, video_data}, 16'h0041);
        chk("char_rt_color", {8'h0, video_color}, {8'h0, m_col[5]});

        // colour write
        cyc(1, 0, 16'h3405, 8'h70, 0, 10'd0);
        idle(2);
        cyc(0, 0, 16'h0000, 8'h00, 1, 10'd5);
        after_edge();
        chk("col_color", {8'h0, video_color}, 16'h0070);
        chk("col_data", {8'h0, video_data}, 16'h0041);

        // FIFO full while video holds the slot
        old4 = m_char[4];
        cyc(1, 0, 16'h3000, 8'h11, 1, 10'd9);
        cyc(1, 0, 16'h3001, 8'h22, 1, 10'd9);
        cyc(1, 0, 16'h3002, 8'h33, 1, 10'd9);
        cyc(1, 0, 16'h3003, 8'h44, 1, 10'd9);
        after_edge();
        chk("full_wait", {15'h0, cpu_wait}, 16'h1);
        cyc(1, 0, 16'h3004, 8'h55, 1, 10'd9);
        idle(5);
        for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0000, 8'h00, 1, 10'(i));
        after_edge();
        chk("full_idx4", {8'h0, video_data}, {8'h0, old4});
        idle(1);

        // forwarding from the youngest queued write
        cyc(1, 0, 16'h3010, 8'hAA, 1, 10'd0);
        cyc(1, 0, 16'h3010, 8'hBB, 1, 10'd0);
        cyc(0, 1, 16'h3010, 8'h00, 1, 10'd0);
        after_edge();
        chk("fwd_valid", {15'h0, cpu_rd_valid}, 16'h1);
        chk("fwd_dout", {8'h0, cpu_dout}, 16'h00BB);
        idle(4);

        // read miss held off by video fetches
        cyc(0, 1, 16'h3020, 8'h00, 1, 10'd1);
        after_edge();
        chk("cont_wait0", {15'h0, cpu_wait}, 16'h1);
        cyc(0, 0, 16'h0000, 8'h00, 1, 10'd2);
        after_edge();
        chk("cont_wait1", {15'h0, cpu_wait}, 16'h1);
        cyc(0, 0, 16'h0000, 8'h00, 1, 10'd3);
        after_edge();
        chk("cont_wait2", {15'h0, cpu_wait}, 16'h1);
        chk("cont_novalid", {15'h0, cpu_rd_valid}, 16'h0);
        idle(1);
        after_edge();
        chk("cont_valid", {15'h0, cpu_rd_valid}, 16'h1);
        chk("cont_dout", {8'h0, cpu_dout}, {8'h0, m_char[10'h020]});
        idle(3);

        // reset while the queue is draining
        old101 = m_char[10'h101];
        cyc(1, 0, 16'h3100, 8'hA1, 1, 10'd0);
        cyc(1, 0, 16'h3101, 8'hA2, 1, 10'd0);
        cyc(1, 0, 16'h3102, 8'hA3, 1, 10'd0);
        idle(1);
        do_reset();
        idle(3);
        cyc(0, 0, 16'h0000, 8'h00, 1, 10'h100);
        cyc(0, 0, 16'h0000, 8'h00, 1, 10'h101);
        after_edge();
        chk("rst_drop_101", {8'h0, video_data}, {8'h0, old101});
        cyc(0, 0, 16'h0000, 8'h00, 1, 10'h102);
        idle(2);

        // randomized traffic over a small index range to exercise forwarding
        vcnt = 0;
        for (int n = 0; n < 4000; n++) begin
            logic vr;
            vr = ($urandom_range(0, 1) == 1) && (vcnt < 7);
            vcnt = vr ? vcnt + 1 : 0;
            idx = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                a = 16'($urandom);
                if (a[15:11] == BASE_C) a[15] = ~a[15];
            end else begin
                a = {BASE_C, 1'($urandom), idx};
            end
            r = $urandom_range(0, 19);
            if (r == 0 && n > 100) do_reset();
            else if (r < 8)  cyc(1, 0, a, 8'($urandom), vr, idx);
            else if (r < 13) cyc(0, 1, a, 8'h00, vr, idx);
            else if (r == 13) cyc(1, 1, a, 8'($urandom), vr, idx);
            else cyc(0, 0, 16'h0000, 8'h00, vr, idx);
        end
        idle(12);
        after_edge();
        chk("end_rq_empty", 16'(rq.size()), 16'h0);
        chk("end_vq_empty", 16'(vq.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
